microwave_cook_sequencer: RTL and testbench

- Central sequencing FSM for the microwave datapath. It takes keypad-entry events, start/stop/clear commands, the door switch, the 1 Hz tick and the countdown timer's zero flag.
- It drives the timer's load, clear and enable strobes and the magnetron output.
- It adds power-level duty cycling of the magnetron and an end-of-cook beep phase.
- It replaces the flat start/stop control path. The timer, encoder and 7-segment decoder stay unchanged.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/power_duty_gen.sv | 38 +++
 rtl/microwave_cook_sequencer.sv | 164 ++++++++++++++++
 tb/tb_microwave_cook_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types, parameter defaults and the power-level clamp for the microwave cook sequencer.
package microwave_pkg;

    localparam int unsigned PWR_WINDOW_DEF = 10;
    localparam int unsigned BEEP_SECS_DEF  = 3;
    localparam int unsigned PWR_W_DEF      = 4;
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Out-of-range requests (0 or above the window) mean full power.
    function automatic int unsigned clamp_power(input int unsigned level, input int unsigned window);
        return (level == 0 || level > window) ? window : level;
    endfunction

endpackage

// File: rtl/power_duty_gen.sv
// Magnetron duty-cycle generator: latches the power level and counts 1 Hz ticks across the window.
module power_duty_gen
    import microwave_pkg::*;
#(
    parameter int unsigned PWR_WINDOW = PWR_WINDOW_DEF,
    parameter int unsigned PWR_W      = PWR_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
    input  logic             tick,
    input  logic [PWR_W-1:0] power_level,
    output logic             on_phase
);

    logic [PWR_W-1:0] duty_cnt;
    logic [PWR_W-1:0] pwr_q;

    // Load restarts the window; otherwise the counter advances only on ticks while running.
    always_ff @(posedge clk) begin
        if (clr) begin
            duty_cnt <= '0;
            pwr_q    <= PWR_W'(PWR_WINDOW);
        end else if (load) begin
            duty_cnt <= '0;
            pwr_q    <= PWR_W'(clamp_power(32'(power_level), PWR_WINDOW));
        end else if (run && tick) begin
            if (duty_cnt == PWR_W'(PWR_WINDOW - 1))
                duty_cnt <= '0;
            else
                duty_cnt <= duty_cnt + PWR_W'(1);
        end
    end

    assign on_phase = (duty_cnt < pwr_q);

endmodule

// File: rtl/microwave_cook_sequencer.sv
// Central cook sequencer: keypad/start/stop/door control, power duty cycling and end-of-cook beep.
// Optional child lock is built when CHILD_LOCK_EN is defined.
module microwave_cook_sequencer
    import microwave_pkg::*;
#(
    parameter int unsigned PWR_WINDOW = PWR_WINDOW_DEF,
    parameter int unsigned BEEP_SECS  = BEEP_SECS_DEF,
    parameter int unsigned PWR_W      = PWR_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             key_valid,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             door_closed,
    input  logic             tick_1hz,
    input  logic             timer_zero,
    input  logic [PWR_W-1:0] power_level,
    output logic             timer_load,
    output logic             timer_clr,
    output logic             timer_en,
    output logic             mag,
    output logic             beep,
    output logic [2:0]       state
`ifdef CHILD_LOCK_EN
    ,
    input  logic             lock_req,
    output logic             locked
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'(S_IDLE);
    localparam logic [2:0] ST_SET   = 3'(S_SET);
    localparam logic [2:0] ST_COOK  = 3'(S_COOK);
    localparam logic [2:0] ST_PAUSE = 3'(S_PAUSE);
    localparam logic [2:0] ST_DONE  = 3'(S_DONE);

    localparam int unsigned BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    logic [2:0]        state_q, state_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              load_d, clr_d;
    logic              pwr_load, duty_run;
    logic              on_phase;
    logic              lock_active;
    logic              key_ok, start_ok;

`ifdef CHILD_LOCK_EN
    // Lock can only be toggled from IDLE so a running cook cannot be locked mid-way.
    always_ff @(posedge clk) begin
        if (clr)
            locked <= 1'b0;
        else if (lock_req && state_q == ST_IDLE)
            locked <= ~locked;
    end
    assign lock_active = locked;
`else
    assign lock_active = 1'b0;
`endif

    assign key_ok   = key_valid & ~lock_active;
    assign start_ok = start & ~lock_active;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            beep_cnt_q <= '0;
            timer_load <= 1'b0;
            timer_clr  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            timer_load <= load_d;
            timer_clr  <= clr_d;
        end
    end

    // Next-state logic; each branch follows clear > timer_zero > door > stop > start > key.
    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        load_d     = 1'b0;
        clr_d      = 1'b0;
        pwr_load   = 1'b0;
        duty_run   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    clr_d = 1'b1;
                end else if (key_ok) begin
                    state_d = ST_SET;
                    load_d  = 1'b1;
                end
            end
            ST_SET: begin
                if (clear || stop) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_ok && door_closed && !timer_zero) begin
                    state_d  = ST_COOK;
                    pwr_load = 1'b1;
                end else if (key_ok) begin
                    load_d = 1'b1;
                end
            end
            ST_COOK: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (timer_zero) begin
                    state_d    = ST_DONE;
                    beep_cnt_d = '0;
                end else begin
                    duty_run = 1'b1;
                    if (!door_closed || stop)
                        state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear || stop) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_ok && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (!door_closed || stop || key_ok) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    if (beep_cnt_q == BEEP_W'(BEEP_SECS - 1))
                        state_d = ST_IDLE;
                    else
                        beep_cnt_d = beep_cnt_q + BEEP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    power_duty_gen #(
        .PWR_WINDOW (PWR_WINDOW),
        .PWR_W      (PWR_W)
    ) u_duty (
        .clk         (clk),
        .clr         (clr),
        .load        (pwr_load),
        .run         (duty_run),
        .tick        (tick_1hz),
        .power_level (power_level),
        .on_phase    (on_phase)
    );

    // Door gates mag combinationally so the magnetron drops the same cycle the door opens.
    assign timer_en = (state_q == ST_COOK);
    assign beep     = (state_q == ST_DONE);
    assign mag      = (state_q == ST_COOK) & door_closed & on_phase;
    assign state    = state_q;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Directed plus randomized bench for microwave_cook_sequencer against a behavioural model.
module tb_microwave_cook_sequencer;

    localparam int WIN = 10;
    localparam int BS  = 3;

    logic       clk = 1'b0;
    logic       clr, key_valid, start, stop, clear, door_closed, tick_1hz, timer_zero;
    logic [3:0] power_level;
    logic       timer_load, timer_clr, timer_en, mag, beep;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode names follow the state encoding I/S/C/P/D = 0..4
    int m_mode, m_duty, m_pwr, m_beeps;
    logic m_load, m_clr;

    logic       obs_mag, obs_beep;
    logic [2:0] obs_state;

    microwave_cook_sequencer dut (
        .clk         (clk),
        .clr         (clr),
        .key_valid   (key_valid),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .tick_1hz    (tick_1hz),
        .timer_zero  (timer_zero),
        .power_level (power_level),
        .timer_load  (timer_load),
        .timer_clr   (timer_clr),
        .timer_en    (timer_en),
        .mag         (mag),
        .beep        (beep),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic nl, nc;
        int   pl;
        nl = 1'b0;
        nc = 1'b0;
        pl = int'(power_level);
        if (clr) begin
            m_mode = 0; m_duty = 0; m_pwr = WIN; m_beeps = 0;
        end else begin
            case (m_mode)
                0: if (clear) nc = 1'b1;
                   else if (key_valid) begin m_mode = 1; nl = 1'b1; end
                1: if (clear || stop) begin m_mode = 0; nc = 1'b1; end
                   else if (start && door_closed && !timer_zero) begin
                       m_mode = 2; m_duty = 0;
                       m_pwr = (pl == 0 || pl > WIN) ? WIN : pl;
                   end else if (key_valid) nl = 1'b1;
                2: if (clear) begin m_mode = 0; nc = 1'b1; end
                   else if (timer_zero) begin m_mode = 4; m_beeps = 0; end
                   else begin
                       if (tick_1hz) m_duty = (m_duty + 1) % WIN;
                       if (!door_closed || stop) m_mode = 3;
                   end
                3: if (clear || stop) begin m_mode = 0; nc = 1'b1; end
                   else if (start && door_closed) m_mode = 2;
                default: if (clear) begin m_mode = 0; nc = 1'b1; end
                   else if (stop || !door_closed || key_valid) m_mode = 0;
                   else if (tick_1hz) begin
                       if (m_beeps == BS - 1) m_mode = 0;
                       else m_beeps++;
                   end
            endcase
        end
        m_load = clr ? 1'b0 : nl;
        m_clr  = clr ? 1'b0 : nc;
    endtask

    // One clock: compare outputs mid-cycle, advance model, then release the pulses.
    task automatic step();
        @(negedge clk);
        obs_mag   = mag;
        obs_beep  = beep;
        obs_state = state;
        chk("state",      8'(state),      8'(m_mode));
        chk("timer_en",   8'(timer_en),   8'(m_mode == 2));
        chk("beep",       8'(beep),       8'(m_mode == 4));
        chk("mag",        8'(mag),        8'(m_mode == 2 && door_closed && m_duty < m_pwr));
        chk("timer_load", 8'(timer_load), 8'(m_load));
        chk("timer_clr",  8'(timer_clr),  8'(m_clr));
        model_step();
        @(posedge clk);
        #1;
        clr = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick_1hz = 1'b0;
    endtask

    initial begin
        int cnt;
        clr = 1'b1; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        door_closed = 1'b1; tick_1hz = 1'b0; timer_zero = 1'b0; power_level = 4'd10;
        m_mode = 0; m_duty = 0; m_pwr = WIN; m_beeps = 0; m_load = 1'b0; m_clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        step();

        // Three digits then clear
        repeat (3) begin key_valid = 1'b1; step(); end
        step();
        chk("set_after_keys", 8'(obs_state), 8'd1);
        clear = 1'b1; step();
        step();
        chk("idle_after_clear", 8'(obs_state), 8'd0);

        // Full power cook, forced zero, beep for exactly BS ticks
        key_valid = 1'b1; step();
        power_level = 4'd10; start = 1'b1; step();
        repeat (3) begin tick_1hz = 1'b1; step(); step(); end
        timer_zero = 1'b1; step();
        timer_zero = 1'b0;
        cnt = 0;
        repeat (5) begin tick_1hz = 1'b1; step(); if (obs_beep) cnt++; end
        chk("beep_ticks", 8'(cnt), 8'(BS));
        chk("idle_after_beep", 8'(obs_state), 8'd0);

        // Power 3: six on-ticks over two windows
        key_valid = 1'b1; step();
        power_level = 4'd3; start = 1'b1; step();
        cnt = 0;
        repeat (20) begin tick_1hz = 1'b1; step(); if (obs_mag) cnt++; end
        chk("pwr3_on_ticks", 8'(cnt), 8'd6);

        // Power 0 behaves as full power
        stop = 1'b1; step();
        stop = 1'b1; step();
        key_valid = 1'b1; step();
        power_level = 4'd0; start = 1'b1; step();
        cnt = 0;
        repeat (12) begin tick_1hz = 1'b1; step(); if (obs_mag) cnt++; end
        chk("pwr0_on_ticks", 8'(cnt), 8'd12);

        // Door drop mid-window, resume, stop from pause
        power_level = 4'd5;
        stop = 1'b1; step();
        stop = 1'b1; step();
        key_valid = 1'b1; step();
        start = 1'b1; step();
        repeat (3) begin tick_1hz = 1'b1; step(); end
        door_closed = 1'b0; step();
        chk("door_mag_drop", 8'(obs_mag), 8'd0);
        door_closed = 1'b1; step();
        chk("paused", 8'(obs_state), 8'd3);
        start = 1'b1; step();
        repeat (3) begin tick_1hz = 1'b1; step(); end
        stop = 1'b1; step();
        stop = 1'b1; step();
        step();

        // start+stop together in SET: stop wins
        key_valid = 1'b1; step();
        start = 1'b1; stop = 1'b1; step();
        step();
        chk("start_stop_set", 8'(obs_state), 8'd0);

        // clear with timer_zero in COOK: no beep
        key_valid = 1'b1; step();
        start = 1'b1; step();
        clear = 1'b1; timer_zero = 1'b1; step();
        timer_zero = 1'b0; step();
        chk("clear_tz_beep", 8'(obs_beep), 8'd0);

        // Reset during cook
        key_valid = 1'b1; step();
        start = 1'b1; step();
        tick_1hz = 1'b1; step();
        clr = 1'b1; step();
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            key_valid   = ($urandom_range(0, 7) == 0);
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 15) == 0);
            clear       = ($urandom_range(0, 29) == 0);
            tick_1hz    = ($urandom_range(0, 3) == 0);
            door_closed = ($urandom_range(0, 11) != 0);
            timer_zero  = ($urandom_range(0, 19) == 0);
            power_level = 4'($urandom_range(0, 15));
            clr         = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
